// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one unified memory between the core and loader ports.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, gnt_q, gnt_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [2:0] cnt_q, cnt_d;
  logic win, last_wait;
  always_comb begin
    win       = (req0 & req1) ? ~last_q : req1;
    last_wait = cnt_q == 3'(READ_LAT - 1);
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = ISSUE;
        gnt_d   = win;
        last_d  = win;
        we_d    = win ? we1 : we0;
        addr_d  = win ? addr1 : addr0;
        wdata_d = win ? wdata1 : wdata0;
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
        cnt_d   = '0;
      end
      WAIT: if (last_wait) begin
        state_d  = DONE;
        rdata0_d = gnt_q ? rdata0_q : mem_rdata;
        rdata1_d = gnt_q ? mem_rdata : rdata1_q;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
    end
  end
  assign mem_en    = state_q == ISSUE;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ack0      = (state_q == DONE) & ~gnt_q;
  assign ack1      = (state_q == DONE) & gnt_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = state_q != IDLE;
  assign gnt_id    = gnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, data return and reset abort.
module tb_mem_port_arbiter;
  localparam int RL = 2;
  logic clk = 0, reset = 1;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [15:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic ack0, ack1, mem_en, mem_we, busy, gnt_id;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [0:255];
  logic [15:0] pipe [0:RL-1];
  logic en_prev = 0;
  int total = 0, bad = 0;
  int ev_id [0:2];
  int ev_c [0:2];

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  // memory model: read data appears exactly RL cycles after the mem_en sample, zero otherwise
  always @(posedge clk) begin
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 16'h0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (reset) mem[8'h10] <= 16'hBEEF;
  end
  assign mem_rdata = pipe[RL-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ack_both", {31'b0, ack0 & ack1}, 0);
    chk("en_width", {31'b0, mem_en & en_prev}, 0);
    en_prev <= mem_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input string t, input bit p, input bit we, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rexp, input int lat);
    int n, ec;
    logic [15:0] ea, ewd;
    logic ewe;
    if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
    else begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    n = 0; ec = -1; ea = 0; ewd = 0; ewe = 0;
    while (!(p ? ack1 : ack0) && n < 30) begin
      step();
      n++;
      if (mem_en) begin ec = n; ea = mem_addr; ewe = mem_we; ewd = mem_wdata; end
    end
    chk({t, ".lat"}, n, lat);
    chk({t, ".en_cyc"}, ec, 1);
    chk({t, ".addr"}, ea, a);
    chk({t, ".we"}, ewe, we);
    if (we) chk({t, ".wdata"}, ewd, wd);
    else chk({t, ".rdata"}, p ? rdata1 : rdata0, rexp);
    chk({t, ".gnt"}, gnt_id, p);
    chk({t, ".other_ack"}, p ? ack0 : ack1, 0);
    req0 = 0; req1 = 0;
    step();
  endtask

  task automatic arb(input int d1, input bit hold0, input int nev);
    int ne;
    ne = 0;
    for (int i = 0; i < 3; i++) begin ev_id[i] = -1; ev_c[i] = -1; end
    req0 = 1; req1 = (d1 == 0);
    for (int n = 0; n < 60 && ne < nev; n++) begin
      if (n == d1) req1 = 1;
      if (ack0 && ne < 3) begin
        ev_id[ne] = 0; ev_c[ne] = n; ne++;
        if (!hold0 || ne == nev) req0 = 0;
      end
      if (ack1 && ne < 3) begin ev_id[ne] = 1; ev_c[ne] = n; ne++; req1 = 0; end
      if (ne < nev) step();
    end
    req0 = 0; req1 = 0;
    step();
  endtask

  initial begin
    repeat (2) step();
    chk("rst.busy", busy, 0);
    chk("rst.mem_en", mem_en, 0);
    chk("rst.ack0", ack0, 0);
    chk("rst.ack1", ack1, 0);
    chk("rst.gnt", gnt_id, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.rdata0", rdata0, 0);
    chk("rst.rdata1", rdata1, 0);
    reset = 0;
    step();
    access("rd0", 0, 0, 16'h0010, 16'h0, 16'hBEEF, 2 + RL);
    access("wr1", 1, 1, 16'h0020, 16'h1234, 16'h0, 2);
    chk("wr1.rdata0_kept", rdata0, 16'hBEEF);
    access("rd0b", 0, 0, 16'h0020, 16'h0, 16'h1234, 2 + RL);
    chk("rd0b.rdata1_kept", rdata1, 0);
    access("rd1", 1, 0, 16'h0010, 16'h0, 16'hBEEF, 2 + RL);
    chk("rd1.rdata0_kept", rdata0, 16'h1234);
    reset = 1;
    step();
    reset = 0;
    we0 = 0; addr0 = 16'h0010; we1 = 0; addr1 = 16'h0020;
    arb(0, 0, 2);
    chk("tie.first", ev_id[0], 0);
    chk("tie.c0", ev_c[0], 2 + RL);
    chk("tie.second", ev_id[1], 1);
    chk("tie.c1", ev_c[1], 2 * (2 + RL) + 1);
    chk("tie.rdata0", rdata0, 16'hBEEF);
    chk("tie.rdata1", rdata1, 16'h1234);
    chk("tie.gnt", gnt_id, 1);
    arb(0, 0, 2);
    chk("tie2.first", ev_id[0], 0);
    chk("tie2.c0", ev_c[0], 2 + RL);
    arb(0, 1, 3);
    chk("starve.id0", ev_id[0], 0);
    chk("starve.id1", ev_id[1], 1);
    chk("starve.c1", ev_c[1], 2 * (2 + RL) + 1);
    chk("starve.id2", ev_id[2], 0);
    chk("starve.c2", ev_c[2], 3 * (3 + RL) - 1);
    we1 = 1; addr1 = 16'h0030; wdata1 = 16'h5555;
    arb(2, 0, 2);
    chk("late.id0", ev_id[0], 0);
    chk("late.c0", ev_c[0], 2 + RL);
    chk("late.id1", ev_id[1], 1);
    chk("late.c1", ev_c[1], 2 + RL + 3);
    chk("late.mem", mem[8'h30], 16'h5555);
    we1 = 0;
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    repeat (3) step();
    chk("mid.busy_before", busy, 1);
    reset = 1;
    step();
    reset = 0; req0 = 0;
    chk("mid.busy", busy, 0);
    chk("mid.mem_en", mem_en, 0);
    chk("mid.ack0", ack0, 0);
    chk("mid.rdata0", rdata0, 0);
    step();
    chk("mid.ack0_next", ack0, 0);
    chk("mid.busy_next", busy, 0);
    access("after", 0, 0, 16'h0010, 16'h0, 16'hBEEF, 2 + RL);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters.
- Requester 0 is the multicycle core control path: fetch, lw and sw traffic.
- Requester 1 is the external loader/debug port, which preloads programs and inspects memory.
- Performs round-robin arbitration, sequences one memory access at a time, and returns a one-cycle ack with registered read data to the winning requester.

Parameters:
- ADDR_W, 16: memory address width.
- DATA_W, 16: memory data width.
- READ_LAT, 1: cycles from the memory sampling mem_en to mem_rdata being valid. Legal values are 1 to 7.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req0  in  1  core request.
- we0  in  1  core write enable; 1 means write.
- addr0  in  ADDR_W  core address.
- wdata0  in  DATA_W  core write data.
- ack0  out  1  core access complete; one-cycle pulse.
- rdata0  out  DATA_W  core read data; valid while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1: the same set for the loader port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.
- gnt_id  out  1  current or last granted requester.

Behaviour:
- Reset:
  - State goes to IDLE.
  - ack0, ack1, mem_en, mem_we, busy = 0.
  - mem_addr, mem_wdata, rdata0, rdata1 = 0.
  - gnt_id = 0.
  - Round-robin pointer last = 1, so the core wins the first tie.
- Reset takes priority over everything. Reset in any state aborts the access, forces mem_en=0 in the following cycle, and no ack is generated.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples req0/req1. If only one is high, that requester is granted.
  - If both are high, the requester != last is granted.
  - On grant, the winner's we/addr/wdata are latched, gnt_id and last are set to the winner, and the next state is ISSUE.
  - No request means stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_en=1, mem_we=latched we.
  - mem_addr and mem_wdata come from the latched fields.
  - A write goes to DONE next; a read goes to WAIT.
- WAIT:
  - A 3-bit counter runs for READ_LAT cycles with mem_en=0.
  - On the last WAIT cycle, mem_rdata is registered into the granted requester's rdata register.
  - Then the state goes to DONE.
- DONE (exactly one cycle):
  - ack of the granted requester = 1.
  - rdata holds the captured value. On writes rdata keeps its previous value.
  - Next state is IDLE.
- Latency, counting the cycle the request is sampled in IDLE as cycle 0:
  - Write: ISSUE at cycle 1, ack at cycle 2.
  - Read: ISSUE at cycle 1, ack at cycle 2+READ_LAT.
  - Minimum back-to-back period is 3 cycles for writes and 3+READ_LAT cycles for reads.
- Requester rules:
  - Hold req high and keep we/addr/wdata stable until ack. Fields are latched at grant, but stability is still required.
  - Drive req low in the cycle after ack unless a new access is intended. A req still high in the IDLE cycle after DONE is a new request.
  - A requester losing arbitration keeps req high. It is granted in the next IDLE pass, which bounds its wait to one access.
- Requests arriving in ISSUE, WAIT or DONE are not sampled; they wait for IDLE.
- Both acks are never high in the same cycle. mem_en is high for exactly one cycle per access.
- rdata0 and rdata1 are separate registers; an access by one requester never disturbs the other's rdata.

Test Plan:
- Core read, READ_LAT=2: req0=1, we0=0, addr0=0x0010, memory returns 0xBEEF -> mem_en at cycle 1 with mem_addr=0x0010; ack0 at cycle 4 with rdata0=0xBEEF; ack1 never high.
- Loader write: req1=1, we1=1, addr1=0x0020, wdata1=0x1234 -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x0020, mem_wdata=0x1234; ack1 at cycle 2.
- Simultaneous req0/req1 reads after reset, READ_LAT=1:
  - Core is granted first (gnt_id=0) and ack0 occurs at cycle 3.
  - Loader is sampled in IDLE at cycle 4 and ack1 occurs at cycle 7.
  - A second tie with the core re-requesting goes to the core (last=1).
- Starvation check: req0 held continuously with back-to-back reads while req1 is held -> accesses alternate 0,1,0,1; ack1 arrives within 2 access periods.
- Reset mid-WAIT, READ_LAT=3: reset asserted during the 2nd WAIT cycle -> next cycle state is IDLE, busy=0, mem_en=0, no ack; the following req0 completes normally.
- Late request: req1 rises while the core is in WAIT -> req1 is not granted until the IDLE cycle after ack0; mem_en never overlaps between accesses.
